// File: rtl/pixel_window_gen.sv
// -----------------------------------------------------------------------------
// pixel_window_gen
//   KSIZE x KSIZE sliding-window generator for a raster-order pixel stream.
//   Previous rows are held in KSIZE-1 line buffers. A register window shifts
//   one new column in for every accepted pixel. Once KSIZE-1 rows and KSIZE-1
//   columns of the current frame are buffered, each accepted pixel produces
//   one registered window, one cycle after the accept. Frame, row-start and
//   row-end markers are presented alongside the window.
//
//   Optional feature macro: PIXWIN_SOF_RESYNC_EN
//     When this macro is defined, the design adds the in_sof input and the
//     err_resync output, so a frame can be re-aligned from the input side.
//
// Ports
//   clk         clock; all logic runs on the rising edge
//   rst         synchronous, active-high reset
//   in_pixel    input pixel, raster order
//   in_valid    in_pixel is valid
//   in_ready    block accepts in_pixel this cycle (combinational)
//   in_sof      (PIXWIN_SOF_RESYNC_EN only) forces this pixel to (0,0)
//   out_window  window; element (r,c) at [(r*KSIZE+c)*PIX_W +: PIX_W]
//               r=0 is the oldest row, c=0 is the leftmost column
//   out_valid   out_window is valid
//   out_ready   downstream accepts the window
//   out_sof     first window of the frame
//   out_eol     last window of a row
//   out_eof     last window of the frame
//   err_resync  (PIXWIN_SOF_RESYNC_EN only) one-cycle pulse when in_sof
//               arrives while the counters are not at (0,0)
// -----------------------------------------------------------------------------
module pixel_window_gen #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int KSIZE = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PIX_W-1:0]               in_pixel,
  input  logic                           in_valid,
  output logic                           in_ready,
`ifdef PIXWIN_SOF_RESYNC_EN
  input  logic                           in_sof,
  output logic                           err_resync,
`endif
  output logic [KSIZE*KSIZE*PIX_W-1:0]   out_window,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sof,
  output logic                           out_eol,
  output logic                           out_eof
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_EMIT = XW'(KSIZE - 1);
  localparam logic [YW-1:0] Y_EMIT = YW'(KSIZE - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_inReady;
  logic          w_accept;
  logic          w_emit;

  logic [PIX_W-1:0] r_lineBuf [KSIZE-1][IMG_W];
  logic [PIX_W-1:0] r_win     [KSIZE][KSIZE];
  logic [PIX_W-1:0] w_col     [KSIZE];
  logic [PIX_W-1:0] w_nextWin [KSIZE][KSIZE];
  logic [KSIZE*KSIZE*PIX_W-1:0] w_winFlat;

  logic [KSIZE*KSIZE*PIX_W-1:0] r_outWindow;
  logic r_outValid;
  logic r_outSof;
  logic r_outEol;
  logic r_outEof;

  // Handshake and effective pixel position. A pending window that has not
  // been taken blocks the input, so nothing advances during a stall. With the
  // resync option, an in_sof pixel is treated as (0,0) regardless of the
  // counters, and every downstream decision uses that effective position.
  always_comb begin
    w_inReady = !rst && (!r_outValid || out_ready);
    w_accept  = in_valid && w_inReady;
`ifdef PIXWIN_SOF_RESYNC_EN
    w_x = in_sof ? '0 : r_x;
    w_y = in_sof ? '0 : r_y;
`else
    w_x = r_x;
    w_y = r_y;
`endif
    w_emit = w_accept && (w_x >= X_EMIT) && (w_y >= Y_EMIT);
  end

  // New column and next window. The highest-index line buffer holds the
  // oldest row, so it feeds row 0. The incoming pixel completes the bottom
  // row. The window shifts left so the newest column lands at c=KSIZE-1.
  // The flattened copy feeds the output register on the accept edge, which
  // gives the one-cycle latency.
  always_comb begin
    for (int r = 0; r < KSIZE - 1; r++) begin
      w_col[r] = r_lineBuf[KSIZE-2-r][w_x];
    end
    w_col[KSIZE-1] = in_pixel;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) begin
        w_nextWin[r][c] = r_win[r][c+1];
      end
      w_nextWin[r][KSIZE-1] = w_col[r];
    end
    w_winFlat = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        w_winFlat[(r*KSIZE+c)*PIX_W +: PIX_W] = w_nextWin[r][c];
      end
    end
  end

  // Data storage: the line-buffer chain and the shift window. These have no
  // reset. Stale contents never reach the output, because emission waits
  // until every element of the window has been refilled from the current
  // frame.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lineBuf[0][w_x] <= in_pixel;
      for (int k = KSIZE - 2; k >= 1; k--) begin
        r_lineBuf[k][w_x] <= r_lineBuf[k-1][w_x];
      end
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          r_win[r][c] <= w_nextWin[r][c];
        end
      end
    end
  end

  // Raster counters and the output register. A new window replaces the
  // current one on the same edge that the current one is consumed, so a
  // continuous stream runs with no bubbles. A suppressed accept (an edge
  // column or one of the first rows) only advances the counters. That is
  // safe, because an accept can only happen when any pending window is
  // being taken on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_outValid  <= 1'b0;
      r_outWindow <= '0;
      r_outSof    <= 1'b0;
      r_outEol    <= 1'b0;
      r_outEof    <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_x == X_LAST) begin
          r_x <= '0;
          r_y <= (w_y == Y_LAST) ? '0 : w_y + YW'(1);
        end else begin
          r_x <= w_x + XW'(1);
          r_y <= w_y;
        end
      end
      if (w_emit) begin
        r_outValid  <= 1'b1;
        r_outWindow <= w_winFlat;
        r_outSof    <= (w_x == X_EMIT) && (w_y == Y_EMIT);
        r_outEol    <= (w_x == X_LAST);
        r_outEof    <= (w_x == X_LAST) && (w_y == Y_LAST);
      end else if (out_ready) begin
        r_outValid <= 1'b0;
        r_outSof   <= 1'b0;
        r_outEol   <= 1'b0;
        r_outEof   <= 1'b0;
      end
    end
  end

`ifdef PIXWIN_SOF_RESYNC_EN
  logic r_errResync;

  // Resync error flag. It pulses for one cycle after an in_sof accept that
  // arrives while the counters are not already at the frame origin.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_errResync <= 1'b0;
    end else begin
      r_errResync <= w_accept && in_sof && ((r_x != '0) || (r_y != '0));
    end
  end

  assign err_resync = r_errResync;
`endif

  assign in_ready   = w_inReady;
  assign out_window = r_outWindow;
  assign out_valid  = r_outValid;
  assign out_sof    = r_outSof;
  assign out_eol    = r_outEol;
  assign out_eof    = r_outEof;

endmodule

// File: tb/tb_pixel_window_gen.sv
// -----------------------------------------------------------------------------
// tb_pixel_window_gen
//   Directed and randomised stimulus for a 4x4, KSIZE=3 pixel_window_gen.
//   The bench keeps its own copy of each frame and its own raster position.
//   On every accepted pixel it pushes the expected window and markers into a
//   queue. A monitor pops that queue whenever the DUT hands over a window.
// -----------------------------------------------------------------------------
module tb_pixel_window_gen;

  localparam int PIX_W   = 8;
  localparam int IMG_W   = 4;
  localparam int IMG_H   = 4;
  localparam int KSIZE   = 3;
  localparam int WIN_W   = KSIZE * KSIZE * PIX_W;
  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic [WIN_W-1:0] win;
    logic             sof;
    logic             eol;
    logic             eof;
  } expWin_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [PIX_W-1:0] in_pixel;
  logic             in_valid;
  logic             in_ready;
  logic [WIN_W-1:0] out_window;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_eol;
  logic             out_eof;
`ifdef PIXWIN_SOF_RESYNC_EN
  logic             in_sof;
  logic             err_resync;
`endif

  expWin_t          expQ[$];
  expWin_t          monE;
  int               checks      = 0;
  int               errors      = 0;
  int               windowsSeen = 0;
  int               sofSeen     = 0;
  int               eofSeen     = 0;
  int               modelX      = 0;
  int               modelY      = 0;
  bit               randReady   = 1'b0;
  logic [PIX_W-1:0] img [IMG_H][IMG_W];

  pixel_window_gen #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .KSIZE(KSIZE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
`ifdef PIXWIN_SOF_RESYNC_EN
    .in_sof     (in_sof),
    .err_resync (err_resync),
`endif
    .out_window (out_window),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Single comparison point: counts the check, and counts and reports any failure.
  task automatic checkOutput(input string tag, input logic [WIN_W-1:0] observed,
                             input logic [WIN_W-1:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Reference model of one accept: optional resync, window emission from the
  // bench's frame copy, then a raster advance.
  task automatic pushModel(input bit sofFlag);
    expWin_t e;
    if (sofFlag) begin
      modelX = 0;
      modelY = 0;
    end
    if (modelX >= KSIZE - 1 && modelY >= KSIZE - 1) begin
      e.win = '0;
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          e.win[(r*KSIZE+c)*PIX_W +: PIX_W] = img[modelY-KSIZE+1+r][modelX-KSIZE+1+c];
        end
      end
      e.sof = (modelX == KSIZE - 1) && (modelY == KSIZE - 1);
      e.eol = (modelX == IMG_W - 1);
      e.eof = (modelX == IMG_W - 1) && (modelY == IMG_H - 1);
      expQ.push_back(e);
    end
    if (modelX == IMG_W - 1) begin
      modelX = 0;
      modelY = (modelY == IMG_H - 1) ? 0 : modelY + 1;
    end else begin
      modelX++;
    end
  endtask

  // Offer pixel img[py][px] until it is accepted. Inputs are driven 1 unit
  // after the rising edge, and in_ready is sampled 1 unit later.
  task automatic applyStimulus(input int px, input int py, input bit sofFlag);
    int waited   = 0;
    bit accepted = 1'b0;
    while (!accepted && waited <= TIMEOUT) begin
      in_pixel  = img[py][px];
      in_valid  = 1'b1;
`ifdef PIXWIN_SOF_RESYNC_EN
      in_sof    = sofFlag;
`endif
      out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (in_ready) begin
        pushModel(sofFlag);
        accepted = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) checkOutput("acceptTimeout", 1'(accepted), 1'b1);
    in_valid = 1'b0;
`ifdef PIXWIN_SOF_RESYNC_EN
    in_sof   = 1'b0;
`endif
  endtask

  // Send one full frame in raster order, with no gap cycles.
  task automatic sendFrame(input bit sofFirst);
    for (int y = 0; y < IMG_H; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        applyStimulus(x, y, sofFirst && x == 0 && y == 0);
      end
    end
  endtask

  // Let any pending window drain out.
  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Check the window count since `start`, and check that the scoreboard is empty.
  task automatic checkCount(input string tag, input int start, input int expected);
    checkOutput(tag, 32'(windowsSeen - start), 32'(expected));
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
  endtask

  // Output monitor, sampled on the falling edge. A window that shows valid
  // and ready here is the one handed over at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !out_ready) checkOutput("inReadyDuringStall", 1'(in_ready), 1'b0);
      if (out_valid && out_ready) begin
        checkOutput("scoreboardNotEmpty", 1'(expQ.size() > 0), 1'b1);
        if (expQ.size() > 0) begin
          monE = expQ.pop_front();
          checkOutput("window", out_window, monE.win);
          checkOutput("markers", {out_sof, out_eol, out_eof}, {monE.sof, monE.eol, monE.eof});
        end
        windowsSeen++;
        if (out_sof) sofSeen++;
        if (out_eof) eofSeen++;
      end
    end
  end

  // Hard stop in case the directed sequence itself gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence: reset, plain frame, stall/hold, back-to-back frames,
  // mid-frame reset, random traffic, and the optional resync.
  initial begin
    int start;
    int sofStart;
    int eofStart;
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        img[y][x] = PIX_W'(y * IMG_W + x);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
`ifdef PIXWIN_SOF_RESYNC_EN
    in_sof    = 1'b0;
`endif
    @(posedge clk);
    #1;
    checkOutput("resetInReady", 1'(in_ready), 1'b0);
    @(posedge clk);
    #1;
    checkOutput("resetOutValid", 1'(out_valid), 1'b0);
    checkOutput("resetOutWindow", out_window, '0);
    checkOutput("resetMarkers", {out_sof, out_eol, out_eof}, 3'b000);
`ifdef PIXWIN_SOF_RESYNC_EN
    checkOutput("resetErrResync", 1'(err_resync), 1'b0);
`endif
    rst = 1'b0;

    $display("[TB] single 4x4 frame");
    start = windowsSeen;
    sendFrame(1'b0);
    drain();
    checkCount("frameWindowCount", start, 4);

    $display("[TB] stall after first window");
    start = windowsSeen;
    for (int i = 0; i < 11; i++) applyStimulus(i % IMG_W, i / IMG_W, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pixel  = img[2][3];
    #1;
    repeat (3) begin
      checkOutput("holdInReady", 1'(in_ready), 1'b0);
      checkOutput("holdValid", 1'(out_valid), 1'b1);
      checkOutput("holdWindow", out_window, expQ[0].win);
      checkOutput("holdSof", 1'(out_sof), 1'(expQ[0].sof));
      @(posedge clk);
      #1;
    end
    for (int i = 11; i < IMG_W * IMG_H; i++) applyStimulus(i % IMG_W, i / IMG_W, 1'b0);
    drain();
    checkCount("stallWindowCount", start, 4);

    $display("[TB] back-to-back frames");
    start    = windowsSeen;
    sofStart = sofSeen;
    eofStart = eofSeen;
    sendFrame(1'b0);
    sendFrame(1'b0);
    drain();
    checkCount("b2bWindowCount", start, 8);
    checkOutput("b2bSofCount", 32'(sofSeen - sofStart), 32'd2);
    checkOutput("b2bEofCount", 32'(eofSeen - eofStart), 32'd2);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 6; i++) applyStimulus(i % IMG_W, i / IMG_W, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midResetInReady", 1'(in_ready), 1'b0);
    checkOutput("midResetOutValid", 1'(out_valid), 1'b0);
    checkOutput("midResetOutWindow", out_window, '0);
    rst    = 1'b0;
    modelX = 0;
    modelY = 0;
    start  = windowsSeen;
    sendFrame(1'b0);
    drain();
    checkCount("afterResetWindowCount", start, 4);

    $display("[TB] random pixels with random out_ready");
    start     = windowsSeen;
    randReady = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int y = 0; y < IMG_H; y++)
        for (int x = 0; x < IMG_W; x++)
          img[y][x] = PIX_W'($urandom_range(0, 255));
      sendFrame(1'b0);
    end
    randReady = 1'b0;
    drain();
    checkCount("randomWindowCount", start, 16);

`ifdef PIXWIN_SOF_RESYNC_EN
    $display("[TB] in_sof resync");
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        img[y][x] = PIX_W'(y * IMG_W + x);
    for (int i = 0; i < 5; i++) applyStimulus(i % IMG_W, i / IMG_W, 1'b0);
    start = windowsSeen;
    applyStimulus(0, 0, 1'b1);
    checkOutput("errResyncPulse", 1'(err_resync), 1'b1);
    applyStimulus(1, 0, 1'b0);
    checkOutput("errResyncClear", 1'(err_resync), 1'b0);
    for (int i = 2; i < IMG_W * IMG_H; i++) applyStimulus(i % IMG_W, i / IMG_W, 1'b0);
    drain();
    checkCount("resyncWindowCount", start, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
